serial_pair_transmitter: RTL

//  Transmit end of the bit-serial compare link. Accepts two parallel WIDTH-bit words,

---
 rtl/serial_pair_transmitter_pkg.sv | 18 +
 rtl/serial_pair_transmitter_piso_shift_reg.sv | 31 +++
 rtl/serial_pair_transmitter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/serial_pair_transmitter_pkg.sv
// Shared state encoding, default word width and flag helper for the serial compare link.
package serial_pair_transmitter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        SHIFT   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    // True when exactly one of the three comparator flags is set.
    function automatic logic one_hot3(input logic g, input logic e, input logic l);
        return (g ^ e ^ l) & ~(g & e & l);
    endfunction

endpackage

// File: rtl/serial_pair_transmitter_piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB first, zero fill.
// Latency: sout shows din MSB the cycle after load.
// Backpressure: none; load has priority over shift.
module piso_shift_reg
    import serial_pair_transmitter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign sout = sr[WIDTH-1];

endmodule

// File: rtl/serial_pair_transmitter.sv
// Serialises two words MSB first to a bit-serial comparator and returns its registered verdict.
// Latency: cmp_clr at n+1, bits n+2..n+WIDTH+1, done at n+WIDTH+2; one pair per WIDTH+3 cycles.
// Backpressure: start only taken while ready=1; starts at other times are dropped, not queued.
module serial_pair_transmitter
    import serial_pair_transmitter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             cmp_clr,
    output logic             bit_valid,
    output logic             x,
    output logic             y,
    input  logic             cmp_g,
    input  logic             cmp_e,
    input  logic             cmp_l,
    output logic             res_g,
    output logic             res_e,
    output logic             res_l,
    output logic             res_err,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          load;
    logic          shift;
    logic          sx;
    logic          sy;

    assign load  = (state == IDLE) && start;
    // The registers advance one step ahead of x/y so each registered bit lands on its SHIFT cycle.
    assign shift = (state == CLEAR) || (state == SHIFT);

    piso_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (a),
        .sout  (sx)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (b),
        .sout  (sy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ready     <= 1'b1;
            cmp_clr   <= 1'b0;
            bit_valid <= 1'b0;
            x         <= 1'b0;
            y         <= 1'b0;
            res_g     <= 1'b0;
            res_e     <= 1'b0;
            res_l     <= 1'b0;
            res_err   <= 1'b0;
            done      <= 1'b0;
        end else begin
            cmp_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        ready   <= 1'b0;
                        cmp_clr <= 1'b1;
                        cnt     <= '0;
                    end
                end
                CLEAR: begin
                    state     <= SHIFT;
                    bit_valid <= 1'b1;
                    x         <= sx;
                    y         <= sy;
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        // Comparator flags are expected to reflect the final bit during this cycle.
                        state     <= CAPTURE;
                        bit_valid <= 1'b0;
                        x         <= 1'b0;
                        y         <= 1'b0;
                        res_g     <= cmp_g;
                        res_e     <= cmp_e;
                        res_l     <= cmp_l;
                        res_err   <= ~one_hot3(cmp_g, cmp_e, cmp_l);
                        done      <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        x   <= sx;
                        y   <= sy;
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
